// File: rtl/tmds_encoder_multi_pkg.sv
// rtl/tmds_encoder_multi_pkg.sv - shared TMDS mode type, code tables and transition-minimising encoder
package tmds_pkg;

  typedef enum logic [2:0] {
    MODE_CONTROL     = 3'd0,
    MODE_VIDEO       = 3'd1,
    MODE_VIDEO_GUARD = 3'd2,
    MODE_DATA_GUARD  = 3'd3,
    MODE_DATA_ISLAND = 3'd4
  } tmds_mode_t;

  // Indexed by {c1,c0}
  localparam logic [9:0] CTRL_CODES [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  localparam logic [9:0] TERC4_CODES [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  localparam logic [9:0] GUARD_A = 10'b1011001100;
  localparam logic [9:0] GUARD_B = 10'b0100110011;

  // Stage-1 transition minimisation; bit 8 set means the XOR chain was used
  function automatic logic [8:0] tm_encode(input logic [7:0] data);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1 = '0;
    for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, data[i]};
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !data[0]);
    q[0] = data[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ data[i]) : (q[i-1] ^ data[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

endpackage

// File: rtl/tmds_encoder_multi_if.sv
// rtl/tmds_encoder_multi_if.sv - symbol bus between timing generator, encoder lanes and serialisers
interface tmds_encoder_multi_if #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 5
);
  logic [2:0]              mode;
  logic [8*NUM_CH-1:0]     data;
  logic [2*NUM_CH-1:0]     ctrl;
  logic [4*NUM_CH-1:0]     terc4;
  logic [10*NUM_CH-1:0]    tmds;
  logic [CNT_W*NUM_CH-1:0] disp;

  modport master (output mode, data, ctrl, terc4, input tmds, disp);
  modport slave  (input mode, data, ctrl, terc4, output tmds, disp);
endinterface

// File: rtl/tmds_encoder_multi_lane.sv
// rtl/tmds_encoder_multi_lane.sv - one TMDS lane: minimisation stage, DC-balance/code stage, disparity
module tmds_lane
  import tmds_pkg::*;
#(
  parameter int LANE_IDX = 0,
  parameter int CNT_W    = 5
) (
  input logic                 clk_in,
  input logic                 rst_n_in,
  tmds_encoder_multi_if.slave lane_if
);

  // Colour position within the blue/green/red rotation
  localparam int COLOUR = LANE_IDX % 3;
  localparam logic signed [CNT_W:0] EIGHT = (CNT_W+1)'(8);
  localparam logic signed [CNT_W:0] TWO   = (CNT_W+1)'(2);
  localparam logic signed [CNT_W:0] ZERO  = '0;

  logic [8:0]              qm_q, qm_d;
  tmds_mode_t              mode_q, mode_d;
  logic [1:0]              ctrl_q;
  logic [3:0]              terc4_q;
  logic [9:0]              tmds_q, tmds_d;
  logic signed [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]              n_ones;
  logic signed [CNT_W:0]   cnt_x, two_n, cnt_sum;
  logic                    unused_cnt_msb;

  // Stage-1 next state: reserved modes fold into CONTROL, video byte is minimised
  always_comb begin
    qm_d   = tm_encode(lane_if.data[7:0]);
    mode_d = (lane_if.mode > 3'd4) ? MODE_CONTROL : tmds_mode_t'(lane_if.mode);
  end

  // Stage-1 register: minimised word travels with its mode and side-band bits
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      qm_q    <= '0;
      mode_q  <= MODE_CONTROL;
      ctrl_q  <= 2'b00;
      terc4_q <= '0;
    end else begin
      qm_q    <= qm_d;
      mode_q  <= mode_d;
      ctrl_q  <= lane_if.ctrl[1:0];
      terc4_q <= lane_if.terc4[3:0];
    end
  end

  // Stage-2 symbol select; counter math is one bit wider then truncated, non-video clears it
  always_comb begin
    n_ones = '0;
    for (int i = 0; i < 8; i++) n_ones = n_ones + {3'b000, qm_q[i]};
    cnt_x        = {cnt_q[CNT_W-1], cnt_q};
    two_n        = '0;
    two_n[4:0]   = {n_ones, 1'b0};
    cnt_sum      = cnt_x;
    tmds_d       = CTRL_CODES[ctrl_q];
    cnt_d        = '0;
    case (mode_q)
      MODE_VIDEO: begin
        if ((cnt_q == '0) || (n_ones == 4'd4)) begin
          if (qm_q[8]) begin
            tmds_d  = {2'b01, qm_q[7:0]};
            cnt_sum = cnt_x + two_n - EIGHT;
          end else begin
            tmds_d  = {2'b10, ~qm_q[7:0]};
            cnt_sum = cnt_x + EIGHT - two_n;
          end
        end else if ((!cnt_q[CNT_W-1] && (n_ones > 4'd4)) ||
                     (cnt_q[CNT_W-1] && (n_ones < 4'd4))) begin
          // Counter is non-zero here, so a clear sign bit means strictly positive
          tmds_d  = {1'b1, qm_q[8], ~qm_q[7:0]};
          cnt_sum = cnt_x + (qm_q[8] ? TWO : ZERO) + EIGHT - two_n;
        end else begin
          tmds_d  = {1'b0, qm_q[8], qm_q[7:0]};
          cnt_sum = cnt_x - (qm_q[8] ? ZERO : TWO) + two_n - EIGHT;
        end
        cnt_d = cnt_sum[CNT_W-1:0];
      end
      MODE_VIDEO_GUARD: tmds_d = (COLOUR == 1) ? GUARD_B : GUARD_A;
      MODE_DATA_GUARD:  tmds_d = (COLOUR == 0) ? TERC4_CODES[terc4_q] : GUARD_B;
      MODE_DATA_ISLAND: tmds_d = TERC4_CODES[terc4_q];
      default:          tmds_d = CTRL_CODES[ctrl_q];
    endcase
  end

  assign unused_cnt_msb = cnt_sum[CNT_W];

  // Stage-2 register: output symbol and running disparity after that symbol
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tmds_q <= '0;
      cnt_q  <= '0;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign lane_if.tmds = tmds_q;
  assign lane_if.disp = cnt_q;

endmodule

// File: rtl/tmds_encoder_multi.sv
// rtl/tmds_encoder_multi.sv - multi-lane DVI/HDMI TMDS encoder, slices buses onto per-lane encoders
module tmds_encoder_multi
  import tmds_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 5
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [2:0]              mode_in,
  input  logic [8*NUM_CH-1:0]     data_in,
  input  logic [2*NUM_CH-1:0]     ctrl_in,
  input  logic [4*NUM_CH-1:0]     terc4_in,
  output logic [10*NUM_CH-1:0]    tmds_out,
  output logic [CNT_W*NUM_CH-1:0] disp_out
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    tmds_encoder_multi_if #(.NUM_CH(1), .CNT_W(CNT_W)) lane_bus ();

    assign lane_bus.mode  = mode_in;
    assign lane_bus.data  = data_in[8*i +: 8];
    assign lane_bus.ctrl  = ctrl_in[2*i +: 2];
    assign lane_bus.terc4 = terc4_in[4*i +: 4];
    assign tmds_out[10*i +: 10]       = lane_bus.tmds;
    assign disp_out[CNT_W*i +: CNT_W] = lane_bus.disp;

    tmds_lane #(.LANE_IDX(i), .CNT_W(CNT_W)) u_lane (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .lane_if  (lane_bus.slave)
    );
  end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// tb/tb_tmds_encoder_multi.sv - scoreboard bench for tmds_encoder_multi
module tb_tmds_encoder_multi;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 5;

  localparam logic [9:0] G_A = 10'b1011001100;
  localparam logic [9:0] G_B = 10'b0100110011;

  typedef struct packed {
    logic [NUM_CH-1:0][9:0] code;
    logic [NUM_CH-1:0][7:0] disp;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mcnt [NUM_CH];
  exp_t sb [$];

  always #5 clk = ~clk;

  tmds_encoder_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  tmds_encoder_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .mode_in  (bus.mode),
    .data_in  (bus.data),
    .ctrl_in  (bus.ctrl),
    .terc4_in (bus.terc4),
    .tmds_out (bus.tmds),
    .disp_out (bus.disp)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ref_ctrl(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] ref_terc4(input logic [3:0] n);
    case (n)
      4'd0:  return 10'b1010011100;  4'd1:  return 10'b1001100011;
      4'd2:  return 10'b1011100100;  4'd3:  return 10'b1011100010;
      4'd4:  return 10'b0101110001;  4'd5:  return 10'b0100011110;
      4'd6:  return 10'b0110001110;  4'd7:  return 10'b0100111100;
      4'd8:  return 10'b1011001100;  4'd9:  return 10'b0100111001;
      4'd10: return 10'b0110011100;  4'd11: return 10'b1011000110;
      4'd12: return 10'b1010001110;  4'd13: return 10'b1001110001;
      4'd14: return 10'b0101100011;  default: return 10'b1011000011;
    endcase
  endfunction

  function automatic logic [8:0] ref_qm(input logic [7:0] d);
    int ones;
    logic xn;
    logic [8:0] q;
    ones = $countones(d);
    xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !xn;
    return q;
  endfunction

  task automatic model(input logic [2:0] m, input logic [8*NUM_CH-1:0] d,
                       input logic [2*NUM_CH-1:0] c, input logic [4*NUM_CH-1:0] t,
                       output exp_t e);
    int mm, col, n, q8;
    logic [8:0] qm;
    logic [9:0] code;
    mm = (m > 3'd4) ? 0 : int'(m);
    for (int l = 0; l < NUM_CH; l++) begin
      col = l % 3;
      code = ref_ctrl(c[2*l +: 2]);
      if (mm == 1) begin
        qm = ref_qm(d[8*l +: 8]);
        n  = $countones(qm[7:0]);
        q8 = int'(qm[8]);
        if (mcnt[l] == 0 || n == 4) begin
          code = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
          mcnt[l] = q8 ? mcnt[l] + 2*n - 8 : mcnt[l] + 8 - 2*n;
        end else if ((mcnt[l] > 0 && n > 4) || (mcnt[l] < 0 && n < 4)) begin
          code = {1'b1, qm[8], ~qm[7:0]};
          mcnt[l] = mcnt[l] + 2*q8 + 8 - 2*n;
        end else begin
          code = {1'b0, qm[8], qm[7:0]};
          mcnt[l] = mcnt[l] - 2*(1 - q8) + 2*n - 8;
        end
      end else begin
        mcnt[l] = 0;
        if (mm == 2) code = (col == 1) ? G_B : G_A;
        else if (mm == 3) code = (col == 0) ? ref_terc4(t[4*l +: 4]) : G_B;
        else if (mm == 4) code = ref_terc4(t[4*l +: 4]);
      end
      e.code[l] = code;
      e.disp[l] = 8'(mcnt[l]);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    int   dv;
    e = sb.pop_front();
    for (int l = 0; l < NUM_CH; l++) begin
      dv = int'($signed(bus.disp[CNT_W*l +: CNT_W]));
      check_eq($sformatf("tmds_l%0d", l), 32'(bus.tmds[10*l +: 10]), 32'(e.code[l]));
      check_eq($sformatf("disp_l%0d", l), dv, int'($signed(e.disp[l])));
      check_eq($sformatf("disp_bound_l%0d", l), 32'(dv >= -10 && dv <= 10), 32'd1);
    end
  endtask

  task automatic step(input logic [2:0] m, input logic [8*NUM_CH-1:0] d,
                      input logic [2*NUM_CH-1:0] c, input logic [4*NUM_CH-1:0] t);
    exp_t e;
    bus.mode  = m;
    bus.data  = d;
    bus.ctrl  = c;
    bus.terc4 = t;
    model(m, d, c, t, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() > 1) compare_front();
  endtask

  // Overrides the newest scoreboard entry for one lane with a literal value
  task automatic pin(input int l, input logic [9:0] code, input int disp);
    exp_t e;
    e = sb[sb.size()-1];
    e.code[l] = code;
    e.disp[l] = 8'(disp);
    sb[sb.size()-1] = e;
  endtask

  task automatic do_reset();
    exp_t e;
    rst_n = 1'b0;
    #1;
    for (int l = 0; l < NUM_CH; l++) begin
      check_eq($sformatf("rst_tmds_l%0d", l), 32'(bus.tmds[10*l +: 10]), 32'd0);
      check_eq($sformatf("rst_disp_l%0d", l), 32'(bus.disp[CNT_W*l +: CNT_W]), 32'd0);
    end
    sb.delete();
    for (int l = 0; l < NUM_CH; l++) mcnt[l] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int l = 0; l < NUM_CH; l++) begin
      e.code[l] = 10'b1101010100;
      e.disp[l] = 8'd0;
    end
    sb.push_back(e);
  endtask

  initial begin
    logic [1:0]  cyc [4];
    logic [23:0] rd;
    logic [5:0]  rc;
    logic [11:0] rt;
    logic [2:0]  rm;
    int          r;
    cyc[0] = 2'b00; cyc[1] = 2'b01; cyc[2] = 2'b10; cyc[3] = 2'b11;
    bus.mode = 3'd0; bus.data = '0; bus.ctrl = '0; bus.terc4 = '0;
    #2;
    do_reset();

    step(3'd1, 24'h000000, 6'd0, 12'd0); pin(0, 10'b0100000000, -8);
    step(3'd1, 24'h000000, 6'd0, 12'd0); pin(0, 10'b1111111111, 2);
    step(3'd1, 24'h000000, 6'd0, 12'd0); pin(0, 10'b0100000000, -6);

    do_reset();
    step(3'd1, 24'hFFFFFF, 6'd0, 12'd0); pin(0, 10'b1000000000, -8);

    step(3'd0, 24'h0, {4'b0000, cyc[0]}, 12'd0); pin(0, 10'b1101010100, 0);
    step(3'd0, 24'h0, {4'b0000, cyc[1]}, 12'd0); pin(0, 10'b0010101011, 0);
    step(3'd0, 24'h0, {4'b0000, cyc[2]}, 12'd0); pin(0, 10'b0101010100, 0);
    step(3'd0, 24'h0, {4'b0000, cyc[3]}, 12'd0); pin(0, 10'b1010101011, 0);

    step(3'd2, 24'h0, 6'd0, 12'd0);
    pin(0, 10'b1011001100, 0); pin(1, 10'b0100110011, 0); pin(2, 10'b1011001100, 0);
    step(3'd3, 24'h0, 6'd0, 12'h00C);
    pin(0, 10'b1010001110, 0); pin(1, 10'b0100110011, 0); pin(2, 10'b0100110011, 0);

    for (int n = 0; n < 16; n++) step(3'd4, 24'h0, 6'd0, {3{4'(n)}});
    step(3'd1, 24'h000000, 6'd0, 12'd0); pin(0, 10'b0100000000, -8);

    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) do_reset();
      r  = int'($urandom_range(0, 9));
      rm = (r < 6) ? 3'd1 : (r < 8) ? 3'd0 : 3'($urandom_range(0, 7));
      rd = 24'($urandom);
      rc = 6'($urandom);
      rt = 12'($urandom);
      step(rm, rd, rc, rt);
    end

    @(posedge clk);
    #1;
    while (sb.size() > 0) compare_front();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tmds_encoder_multi.md
# tmds_encoder_multi

Parametrised, two-stage pipelined TMDS encoder for `NUM_CH` lanes that adds HDMI data-island support (TERC4 plus video and data guard bands) alongside DVI video and control encoding. Each lane keeps its own running-disparity counter, and all lanes share one mode select. The block sits between the video/packet timing generator and the 10:1 serialisers, and outputs one 10-bit symbol per lane per pixel clock.

## Interface
- `NUM_CH`, default 3: number of lanes. Lane 0 is blue, lane 1 green, lane 2 red; above lane 2 the pattern repeats with index mod 3.
- `CNT_W`, default 5: signed width of each lane's disparity counter. Must be ≥5.
- `clk_in`, input, 1: pixel clock. All logic sits in this one clock domain.
- `rst_n_in`, input, 1: reset, asynchronous and active-low.
- `mode_in`, input, 3: symbol type for this cycle, shared by all lanes.
- `data_in`, input, 8*NUM_CH: video byte per lane; lane i is `[8i+7:8i]`.
- `ctrl_in`, input, 2*NUM_CH: control bits per lane; lane 0 carries {vs,hs}.
- `terc4_in`, input, 4*NUM_CH: data-island nibble per lane.
- `tmds_out`, output, 10*NUM_CH: encoded symbol per lane; lane i is `[10i+9:10i]`.
- `disp_out`, output, CNT_W*NUM_CH: signed running disparity per lane, after the current symbol.

## Operation
- Modes:
  - 0 CONTROL
  - 1 VIDEO
  - 2 VIDEO_GUARD
  - 3 DATA_GUARD
  - 4 DATA_ISLAND
  - 5–7 behave exactly as CONTROL.
- Stage 1 (per lane):
  - Transition minimisation. With n1 = ones(data): if n1>4, or (n1==4 and data[0]==0), use the XNOR chain and q_m[8]=0. Otherwise use the XOR chain and q_m[8]=1. In both chains q_m[0]=data[0].
  - Registers q_m, mode, ctrl and terc4.
- Stage 2, VIDEO: DC balance. N = ones(q_m[7:0]); cnt is signed.
  - If cnt==0 or N==4: out = {~q_m8, q_m8, q_m8 ? q_m : ~q_m}. New cnt = cnt+8−2N when q_m8=0, else cnt+2N−8.
  - Else if (cnt>0 and N>4) or (cnt<0 and N<4): out = {1, q_m8, ~q_m}, new cnt = cnt + 2·q_m8 + 8 − 2N.
  - Else: out = {0, q_m8, q_m}, new cnt = cnt − 2·(~q_m8) + 2N − 8.
- CONTROL codes:
  - 00 → 1101010100
  - 01 → 0010101011
  - 10 → 0101010100
  - 11 → 1010101011
- VIDEO_GUARD: lanes with i mod 3 == 1 output 0100110011; all other lanes output 1011001100.
- DATA_GUARD: lanes with i mod 3 == 0 output TERC4(terc4_in); all other lanes output 0100110011.
- DATA_ISLAND: each lane outputs TERC4(terc4_in). TERC4 codes 0–15:
  - 0 → 1010011100, 1 → 1001100011, 2 → 1011100100, 3 → 1011100010
  - 4 → 0101110001, 5 → 0100011110, 6 → 0110001110, 7 → 0100111100
  - 8 → 1011001100, 9 → 0100111001, 10 → 0110011100, 11 → 1011000110
  - 12 → 1010001110, 13 → 1001110001, 14 → 0101100011, 15 → 1011000011
- Any non-VIDEO symbol clears that lane's cnt to 0 in the same stage-2 update.
- Counter arithmetic is done at CNT_W+1 bits and truncated to CNT_W. Legal streams never exceed ±10.

## Timing
- Latency is 2 cycles: inputs sampled at edge k appear on `tmds_out`/`disp_out` after edge k+1. Throughput is 1 symbol per cycle per lane.
- No handshake and no stalls; every cycle produces a symbol.
- While `rst_n_in`=0, asynchronously: `tmds_out`=0, `disp_out`=0, stage-1 mode=CONTROL, ctrl=00, q_m=0.
- First edge after release: `tmds_out` = 1101010100 on all lanes.
- Reset asserted mid-stream aborts immediately with no partial symbol. Disparity restarts at 0.
- A mode change takes effect on exactly the symbol sampled with it, pipelined alongside its data. VIDEO→other→VIDEO re-enters video with cnt=0.

## Structure
- Package `tmds_pkg` holds:
  - the `tmds_mode_t` enum
  - the constants `CTRL_CODES[4]`, `TERC4_CODES[16]`, `GUARD_A` (1011001100) and `GUARD_B` (0100110011)
  - the function `tm_encode(data) → [8:0]`.
- Sub-module `tmds_lane`: one lane, both stages and its disparity register. It takes `LANE_IDX` and `CNT_W` as parameters and is instantiated `NUM_CH` times by `generate`. The top level only slices buses.

## Test plan
- Reset, then VIDEO with 0x00 on lane 0 for 3 cycles: outputs 0100000000 (cnt −8), 1111111111 (cnt 2), 0100000000 (cnt −6).
- From reset, VIDEO 0xFF: output 1000000000, `disp_out` −8.
- CONTROL with lane-0 ctrl cycling 00, 01, 10, 11: outputs 1101010100, 0010101011, 0101010100, 1010101011, each 2 cycles after its input. `disp_out`=0 throughout.
- VIDEO_GUARD on 3 lanes: outputs 1011001100 / 0100110011 / 1011001100. DATA_GUARD with lane-0 terc4=0xC: lane 0 outputs 1010001110, lanes 1 and 2 output 0100110011.
- DATA_ISLAND sweeping terc4 0–15 on all lanes: outputs match the TERC4 list in order. A following VIDEO 0x00 outputs 0100000000, confirming cnt restarted at 0.
- Random 10k-cycle video/control mix, with `rst_n_in` pulsed low mid-stream. Outputs match a reference model, |cnt|≤10 at all times, and reset values appear within the same cycle as assertion.
